// File: rtl/traffic_lane.sv
// One lane of up to MaxCars cars: spawn-time spacing divide, per-frame motion with wrap, hit flags, pixel lookup.
// Optional speed ramp every 64 frames when TRAFFIC_LANE_SPEEDUP_EN is defined.
module traffic_lane #(
    parameter int TileY      = 0,
    parameter int MaxCars    = 8,
    parameter int CarWidth   = 48,
    parameter int CarHeight  = 26,
    parameter int ScreenW    = 640,
    parameter int PlayerSize = 16,
    localparam int CW        = $clog2(MaxCars + 1)
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          FrameTick,
    input  logic          SpawnEnable,
    input  logic          Direction,
    input  logic [1:0]    CarType,
    input  logic [CW-1:0] CarCount,
    input  logic [2:0]    CarSpeed,
    input  logic [4:0]    P1HbOffset,
    input  logic [4:0]    P2HbOffset,
    input  logic [9:0]    DrawX,
    input  logic [9:0]    DrawY,
    input  logic [9:0]    P1X,
    input  logic [9:0]    P1Y,
    input  logic [9:0]    P2X,
    input  logic [9:0]    P2Y,
    output logic          Busy,
    output logic          P1Hit,
    output logic          P2Hit,
    output logic          CarPixel,
    output logic [3:0]    Tile,
    output logic [5:0]    PixelX,
    output logic [4:0]    PixelY,
    output logic [2:0]    DbgState
);
    localparam logic [10:0] WORLD_W = 11'(ScreenW + CarWidth);
    localparam logic [9:0]  SPAWN_Y = 10'(16 * TileY - 10);

    // FrameTick and SpawnEnable are single-cycle strobes with no backpressure; Busy flags a spawn in progress.
    typedef enum logic [2:0] {IDLE, LOAD, DIV, SPAWN, RUN} state_t;
    state_t state;

    logic              face_left;
    logic [1:0]        car_type;
    logic [2:0]        speed;
    logic [CW-1:0]     count;
    logic [MaxCars-1:0] valid;
    logic [10:0]       pos [MaxCars];
    logic [10:0]       quo;
    logic [CW-1:0]     rem;
    logic [3:0]        div_cnt;
    logic [CW-1:0]     k;
    logic [10:0]       pos_acc;
    logic              tick_d;
`ifdef TRAFFIC_LANE_SPEEDUP_EN
    logic [5:0]        frame_cnt;
`endif

    logic [CW-1:0] count_in;
    logic [11:0]   prod;
    logic [10:0]   num_in;
    logic [CW:0]   rem_sh;
    logic          div_ge;
    logic          p1_any, p2_any, pix_found;
    logic [5:0]    pix_x;
    logic [4:0]    pix_y;

    assign DbgState = state;
    assign count_in = (CarCount > CW'(MaxCars)) ? CW'(MaxCars) : CarCount;
    assign prod     = 12'(CarWidth) * 12'(count_in);
    assign num_in   = (prod >= 12'(WORLD_W)) ? 11'd0 : 11'(12'(WORLD_W) - prod);
    assign rem_sh   = {rem, quo[10]};
    assign div_ge   = rem_sh >= {1'b0, count};

    function automatic logic [10:0] move(input logic [10:0] p, input logic left, input logic [2:0] s);
        logic [10:0] sp;
        sp = {8'd0, s};
        if (left) move = (p >= sp) ? p - sp : p + WORLD_W - sp;
        else      move = (p + sp >= WORLD_W) ? p + sp - WORLD_W : p + sp;
    endfunction

    // Car box is [p-CarWidth, p); comparisons are shifted by CarWidth so everything stays unsigned.
    function automatic logic box_hit(input logic [10:0] p, input logic [9:0] px, input logic [9:0] py,
                                     input logic [4:0] off);
        logic [11:0] hx0, hx1;
        hx0 = 12'(px) + 12'(off);
        hx1 = 12'(px) + 12'(PlayerSize) - 12'(off);
        if (12'(2 * off) >= 12'(PlayerSize)) box_hit = 1'b0;
        else box_hit = (hx0 < 12'(p)) && (12'(p) < hx1 + 12'(CarWidth)) &&
                       (12'(py) < 12'(SPAWN_Y) + 12'(CarHeight)) &&
                       (12'(SPAWN_Y) < 12'(py) + 12'(PlayerSize));
    endfunction

    always_comb begin
        p1_any    = 1'b0;
        p2_any    = 1'b0;
        pix_found = 1'b0;
        pix_x     = 6'd0;
        pix_y     = 5'(DrawY - SPAWN_Y);
        // Descending scan so the lowest-index covering car is the last writer.
        for (int i = MaxCars - 1; i >= 0; i--) begin
            if (valid[i] && box_hit(pos[i], P1X, P1Y, P1HbOffset)) p1_any = 1'b1;
            if (valid[i] && box_hit(pos[i], P2X, P2Y, P2HbOffset)) p2_any = 1'b1;
            if (valid[i] && (12'(pos[i]) <= 12'(DrawX) + 12'(CarWidth)) && (12'(DrawX) < 12'(pos[i])) &&
                (DrawY >= SPAWN_Y) && (12'(DrawY) < 12'(SPAWN_Y) + 12'(CarHeight))) begin
                pix_found = 1'b1;
                pix_x     = 6'(12'(DrawX) + 12'(CarWidth) - 12'(pos[i]));
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            Busy      <= 1'b0;
            face_left <= 1'b0;
            car_type  <= 2'd0;
            speed     <= 3'd0;
            count     <= '0;
            valid     <= '0;
            for (int i = 0; i < MaxCars; i++) pos[i] <= 11'd0;
            quo       <= 11'd0;
            rem       <= '0;
            div_cnt   <= 4'd0;
            k         <= '0;
            pos_acc   <= 11'd0;
            tick_d    <= 1'b0;
            P1Hit     <= 1'b0;
            P2Hit     <= 1'b0;
            CarPixel  <= 1'b0;
            Tile      <= 4'd0;
            PixelX    <= 6'd0;
            PixelY    <= 5'd0;
`ifdef TRAFFIC_LANE_SPEEDUP_EN
            frame_cnt <= 6'd0;
`endif
        end else begin
            tick_d   <= 1'b0;
            CarPixel <= pix_found;
            Tile     <= pix_found ? {1'b0, car_type, face_left} : 4'd0;
            PixelX   <= pix_found ? pix_x : 6'd0;
            PixelY   <= pix_found ? pix_y : 5'd0;
            if (tick_d) begin
                P1Hit <= p1_any;
                P2Hit <= p2_any;
            end
            if (SpawnEnable) begin
                state <= LOAD;
                Busy  <= 1'b1;
            end else begin
                case (state)
                    IDLE: ;
                    LOAD: begin
                        face_left <= Direction;
                        car_type  <= CarType;
                        speed     <= CarSpeed;
                        count     <= count_in;
                        valid     <= '0;
                        quo       <= num_in;
                        rem       <= '0;
                        div_cnt   <= 4'd0;
                        k         <= '0;
                        pos_acc   <= 11'd0;
`ifdef TRAFFIC_LANE_SPEEDUP_EN
                        frame_cnt <= 6'd0;
`endif
                        if (count_in == '0) begin
                            state <= RUN;
                            Busy  <= 1'b0;
                        end else begin
                            state <= DIV;
                        end
                    end
                    DIV: begin
                        quo     <= {quo[9:0], div_ge};
                        rem     <= div_ge ? CW'(rem_sh - {1'b0, count}) : CW'(rem_sh);
                        div_cnt <= div_cnt + 4'd1;
                        if (div_cnt == 4'd10) state <= SPAWN;
                    end
                    SPAWN: begin
                        for (int i = 0; i < MaxCars; i++) begin
                            if (CW'(i) == k) begin
                                pos[i]   <= pos_acc;
                                valid[i] <= 1'b1;
                            end
                        end
                        pos_acc <= pos_acc + quo + 11'(CarWidth);
                        if (k == count - CW'(1)) begin
                            state <= RUN;
                            Busy  <= 1'b0;
                        end else begin
                            k <= k + CW'(1);
                        end
                    end
                    RUN: begin
                        if (FrameTick) begin
                            tick_d <= 1'b1;
                            for (int i = 0; i < MaxCars; i++)
                                if (valid[i]) pos[i] <= move(pos[i], face_left, speed);
`ifdef TRAFFIC_LANE_SPEEDUP_EN
                            frame_cnt <= frame_cnt + 6'd1;
                            if (frame_cnt == 6'd63 && speed != 3'd7) speed <= speed + 3'd1;
`endif
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_traffic_lane.sv
// Directed and randomized bench for traffic_lane with an arithmetic lane model (TileY = 10, lane rows 150..175).
module tb_traffic_lane;
    localparam int MAXC = 8;
    localparam int WW   = 688;
    localparam int SY   = 150;

    logic clk, reset, frame_tick, spawn_enable, direction;
    logic [1:0] car_type;
    logic [3:0] car_count;
    logic [2:0] car_speed;
    logic [4:0] p1_off, p2_off;
    logic [9:0] draw_x, draw_y, p1x, p1y, p2x, p2y;
    logic busy, p1_hit, p2_hit, car_pixel;
    logic [3:0] tile;
    logic [5:0] pixel_x;
    logic [4:0] pixel_y;
    logic [2:0] dbg_state;

    int checks = 0;
    int errors = 0;

    int m_cnt = 0, m_spd = 0, m_typ = 0, m_lft = 0;
    int m_pos [MAXC];

    traffic_lane #(.TileY(10)) dut (
        .Clk(clk), .Reset(reset), .FrameTick(frame_tick), .SpawnEnable(spawn_enable),
        .Direction(direction), .CarType(car_type), .CarCount(car_count), .CarSpeed(car_speed),
        .P1HbOffset(p1_off), .P2HbOffset(p2_off), .DrawX(draw_x), .DrawY(draw_y),
        .P1X(p1x), .P1Y(p1y), .P2X(p2x), .P2Y(p2y), .Busy(busy), .P1Hit(p1_hit), .P2Hit(p2_hit),
        .CarPixel(car_pixel), .Tile(tile), .PixelX(pixel_x), .PixelY(pixel_y), .DbgState(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL timeout reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Model: spacing from integer division, position k = k * pitch.
    function automatic void m_spawn(input int cc, input int dir, input int spd, input int typ);
        int spacing;
        m_cnt = (cc > MAXC) ? MAXC : cc;
        m_lft = dir; m_spd = spd; m_typ = typ;
        spacing = (m_cnt > 0) ? (WW - 48 * m_cnt) / m_cnt : 0;
        for (int i = 0; i < MAXC; i++) m_pos[i] = (i * (spacing + 48)) % 2048;
    endfunction

    function automatic void m_tick();
        for (int i = 0; i < m_cnt; i++)
            m_pos[i] = m_lft ? (m_pos[i] - m_spd + WW) % WW : (m_pos[i] + m_spd) % WW;
    endfunction

    function automatic int m_hit(input int px, input int py, input int off);
        int left;
        if (2 * off >= 16) return 0;
        for (int i = 0; i < m_cnt; i++) begin
            left = m_pos[i] - 48;
            if (px + off < left + 48 && left < px + 16 - off && py < SY + 26 && SY < py + 16) return 1;
        end
        return 0;
    endfunction

    task automatic start_spawn(input int cc, input int dir, input int spd, input int typ);
        car_count = 4'(cc); direction = dir[0]; car_speed = 3'(spd); car_type = 2'(typ);
        spawn_enable = 1'b1;
        step();
        spawn_enable = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 100) begin
            n++;
            step();
        end
    endtask

    task automatic spawn(input string tag, input int cc, input int dir, input int spd, input int typ);
        int n, c;
        start_spawn(cc, dir, spd, typ);
        wait_idle(n);
        c = (cc > MAXC) ? MAXC : cc;
        check({tag, "_busy_len"}, n, (c == 0) ? 1 : 12 + c);
        m_spawn(cc, dir, spd, typ);
    endtask

    task automatic frame(input string tag);
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        m_tick();
        step();
        check({tag, "_p1hit"}, p1_hit, m_hit(p1x, p1y, p1_off));
        check({tag, "_p2hit"}, p2_hit, m_hit(p2x, p2y, p2_off));
    endtask

    task automatic probe(input string tag, input int dx, input int dy);
        int f = 0, ex = 0, ey = 0, et = 0, left;
        draw_x = dx[9:0]; draw_y = dy[9:0];
        step();
        if (dy >= SY && dy < SY + 26)
            for (int i = 0; i < m_cnt; i++) begin
                left = m_pos[i] - 48;
                if (f == 0 && dx >= left && dx < left + 48) begin
                    f = 1; ex = dx - left; ey = dy - SY; et = m_typ * 2 + m_lft;
                end
            end
        check({tag, "_pix"}, car_pixel, f);
        check({tag, "_tile"}, tile, et);
        check({tag, "_px"}, pixel_x, ex);
        check({tag, "_py"}, pixel_y, ey);
    endtask

    task automatic set_players(input int ax, input int ay, input int ao, input int bx, input int by, input int bo);
        p1x = 10'(ax); p1y = 10'(ay); p1_off = 5'(ao);
        p2x = 10'(bx); p2y = 10'(by); p2_off = 5'(bo);
    endtask

    initial begin
        reset = 1'b1; frame_tick = 0; spawn_enable = 0; direction = 0; car_type = 0;
        car_count = 0; car_speed = 0; p1_off = 0; p2_off = 0; draw_x = 0; draw_y = 0;
        p1x = 0; p1y = 0; p2x = 0; p2y = 0;
        step(); step();
        check("rst_busy", busy, 0);
        check("rst_state", dbg_state, 0);
        check("rst_p1", p1_hit, 0);
        check("rst_pix", car_pixel, 0);
        check("rst_tile", tile, 0);
        reset = 1'b0;
        step();

        // Four stationary cars: pitch 172, lefts -48, 124, 296, 468
        spawn("c4", 4, 0, 0, 2);
        check("c4_busy_const", busy, 0);
        probe("c1p5", 124 + 5, SY + 3);
        check("c1p5_px_const", pixel_x, 5);
        check("c1p5_py_const", pixel_y, 3);
        check("c1p5_tile_const", tile, 4);
        probe("c1_last", 171, SY);
        probe("gap", 172, SY + 10);
        probe("c2_first", 296, SY + 25);
        probe("below", 300, SY + 26);
        probe("above", 300, SY - 1);

        // Two cars, car1 box x 296..343
        spawn("c2", 2, 0, 0, 1);
        set_players(341, SY, 2, 0, 0, 0);
        frame("ov1");
        check("ov1_const", p1_hit, 1);
        check("ov1_p2_const", p2_hit, 0);
        set_players(342, SY, 2, 0, 0, 0);
        step(); step();
        check("hold_p1", p1_hit, 1);
        frame("touch_x");
        check("touch_x_const", p1_hit, 0);
        set_players(341, SY - 16, 2, 300, 160, 3);
        frame("touch_y");
        check("p2_only_const", p2_hit, 1);
        set_players(341, SY - 15, 2, 0, 0, 0);
        frame("ov_y");
        set_players(320, SY, 8, 0, 0, 7);
        frame("empty_hb");
        check("empty_hb_const", p1_hit, 0);

        // Single car wrapping leftwards from position 0
        spawn("wrap", 1, 1, 3, 3);
        set_players(0, 0, 0, 0, 0, 0);
        frame("wrap1");
        probe("wrap1_edge", 637, SY);
        check("wrap1_px_const", pixel_x, 0);
        probe("wrap1_out", 636, SY);
        frame("wrap2");
        probe("wrap2_in", 636, SY);
        check("wrap2_px_const", pixel_x, 2);

        // Car straddling the left screen edge
        spawn("clip", 1, 0, 5, 0);
        frame("clip1");
        probe("clip_x0", 0, SY + 1);
        check("clip_x0_const", pixel_x, 43);
        probe("clip_x4", 4, SY + 1);
        probe("clip_x5", 5, SY + 1);

        // Count clamps to MaxCars
        spawn("c15", 15, 0, 0, 1);
        probe("c15_k7", 554, SY);
        check("c15_k7_const", car_pixel, 1);
        for (int x = 0; x < 700; x += 23) probe("c15_scan", x, SY + 4);

        // Relaunch from DIV uses the new configuration
        begin
            int n;
            start_spawn(3, 1, 6, 2);
            step(); step(); step();
            check("relaunch_in_div", dbg_state, 2);
            start_spawn(4, 0, 1, 1);
            wait_idle(n);
            check("relaunch_busy_len", n, 16);
            m_spawn(4, 0, 1, 1);
        end
        frame("rl1");
        for (int x = 100; x < 640; x += 61) probe("rl_scan", x, SY + 12);

        // Random lanes against the model
        for (int r = 0; r < 6; r++) begin
            spawn("rnd", $urandom_range(0, 15), $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 3));
            for (int f = 0; f < 8; f++) begin
                set_players($urandom_range(0, 700), $urandom_range(120, 190), $urandom_range(0, 9),
                            $urandom_range(0, 700), $urandom_range(120, 190), $urandom_range(0, 9));
                frame("rnd_f");
                probe("rnd_p", $urandom_range(0, 700), $urandom_range(145, 180));
            end
        end

        // Asynchronous reset while placing five cars
        set_players(341, SY, 0, 341, SY, 0);
        start_spawn(5, 0, 0, 1);
        for (int i = 0; i < 13; i++) step();
        check("mid_spawn_state", dbg_state, 3);
        check("mid_spawn_busy", busy, 1);
        #2 reset = 1'b1;
        #1;
        check("arst_busy", busy, 0);
        check("arst_state", dbg_state, 0);
        check("arst_p1", p1_hit, 0);
        check("arst_p2", p2_hit, 0);
        check("arst_pix", car_pixel, 0);
        step();
        reset = 1'b0;
        m_cnt = 0;
        for (int x = 0; x < 700; x += 50) probe("arst_scan", x, SY + 5);
        check("arst_idle", dbg_state, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
